// File: rtl/conv3x3_frame_sequencer.sv
// Frame-level controller for the 3x3 convolution engine: streams one frame from
// source memory into the engine and writes the engine's results to destination memory.
module conv3x3_frame_sequencer #(
    parameter int DATA_WIDHT    = 32,
    parameter int IMG_WIDTH     = 220,
    parameter int IMG_HEIGHT    = 220,
    parameter int ADDR_WIDTH    = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Src_Base,
    input  logic [ADDR_WIDTH-1:0] Dst_Base,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [31:0]           Out_Count,
    output logic                  Rd_En,
    output logic [ADDR_WIDTH-1:0] Rd_Addr,
    input  logic [DATA_WIDHT-1:0] Rd_Data,
    output logic                  Conv_Clr,
    output logic [DATA_WIDHT-1:0] Conv_Data,
    output logic                  Conv_Valid,
    input  logic [DATA_WIDHT-1:0] Conv_Result,
    input  logic                  Conv_Result_Valid,
    output logic                  Wr_En,
    output logic [ADDR_WIDTH-1:0] Wr_Addr,
    output logic [DATA_WIDHT-1:0] Wr_Data
);

    localparam int N = IMG_WIDTH * IMG_HEIGHT;
    localparam int M = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] src_base;
    logic [ADDR_WIDTH-1:0] dst_base;
    logic [31:0]           pix_cnt;
    logic [31:0]           idle_cnt;
    logic [31:0]           idle_next;
    logic                  start_ok;
    logic                  capture;
    logic                  last_pixel;
    logic                  frame_complete;
    logic                  drain_timeout;

    assign start_ok   = (state == S_IDLE) && Start;
    assign capture    = ((state == S_CLEAR) || (state == S_FETCH) || (state == S_DRAIN))
                        && Conv_Result_Valid && (Out_Count < 32'(M));
    assign last_pixel = (pix_cnt == 32'(N - 1));

    // Completion looks at the count including a write being issued this cycle,
    // so it wins over a timeout that expires in the same cycle.
    assign frame_complete = capture ? (Out_Count == 32'(M - 1)) : (Out_Count == 32'(M));
    assign idle_next      = Conv_Result_Valid ? 32'd0 : idle_cnt + 32'd1;
    assign drain_timeout  = (idle_next == 32'(DRAIN_TIMEOUT));

    assign Rd_Addr = Rd_En ? (src_base + ADDR_WIDTH'(pix_cnt)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        Busy       = 1'b1;
        Done       = 1'b0;
        Conv_Clr   = 1'b0;
        Rd_En      = 1'b0;
        case (state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                Conv_Clr   = 1'b1;
                next_state = S_FETCH;
            end
            S_FETCH: begin
                Rd_En = 1'b1;
                if (last_pixel) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (frame_complete || drain_timeout) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                Done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: pixel forwarding, result capture, frame counters and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_base   <= '0;
            dst_base   <= '0;
            pix_cnt    <= '0;
            idle_cnt   <= '0;
            Out_Count  <= '0;
            Error      <= 1'b0;
            Conv_Data  <= '0;
            Conv_Valid <= 1'b0;
            Wr_En      <= 1'b0;
            Wr_Addr    <= '0;
            Wr_Data    <= '0;
        end else begin
            Conv_Valid <= Rd_En;
            if (Rd_En) begin
                Conv_Data <= Rd_Data;
            end

            Wr_En <= capture;
            if (capture) begin
                Wr_Addr   <= dst_base + ADDR_WIDTH'(Out_Count);
                Wr_Data   <= Conv_Result;
                Out_Count <= Out_Count + 32'd1;
            end

            if (start_ok) begin
                src_base  <= Src_Base;
                dst_base  <= Dst_Base;
                Error     <= 1'b0;
                Out_Count <= '0;
                pix_cnt   <= '0;
                idle_cnt  <= '0;
            end

            if (state == S_FETCH) begin
                pix_cnt <= pix_cnt + 32'd1;
            end

            if (state == S_DRAIN) begin
                idle_cnt <= idle_next;
                if (!frame_complete && drain_timeout) begin
                    Error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_frame_sequencer.sv
// Scoreboard bench for conv3x3_frame_sequencer on a 5x5 frame with a behavioural
// engine; a second 8-bit-address instance covers address wrap-around.
module tb_conv3x3_frame_sequencer;

    localparam int          W        = 5;
    localparam int          H        = 5;
    localparam int          TO       = 16;
    localparam logic [31:0] PIX_BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 1'b0;
    logic        start8  = 1'b0;
    logic [15:0] src16   = '0;
    logic [15:0] dst16   = '0;
    logic [7:0]  src8    = '0;
    logic [7:0]  dst8    = '0;
    logic [15:0] mem_base16 = '0;
    logic [7:0]  mem_base8  = '0;

    logic        busy16, done16, error16, rd_en16, clr16, cvalid16, wr_en16;
    logic [31:0] oc16, rd_data16, cdata16, wr_data16;
    logic [15:0] rd_addr16, wr_addr16, off16;
    logic        busy8, done8, error8, rd_en8, clr8, cvalid8, wr_en8;
    logic [31:0] oc8, rd_data8, cdata8, wr_data8;
    logic [7:0]  rd_addr8, wr_addr8, off8;

    logic        inj_valid = 1'b0;
    logic [31:0] inj_data  = '0;
    logic        eng_valid = 1'b0;
    logic [31:0] eng_data  = '0;
    logic        res_valid;
    logic [31:0] res_data;

    assign res_valid = eng_valid | inj_valid;
    assign res_data  = inj_valid ? inj_data : eng_data;

    // Source memories: pixel value is PIX_BASE plus the offset from the frame base.
    assign off16     = rd_addr16 - mem_base16;
    assign off8      = rd_addr8 - mem_base8;
    assign rd_data16 = rd_en16 ? (PIX_BASE + {16'h0, off16}) : 32'hDEAD_BEEF;
    assign rd_data8  = rd_en8 ? (PIX_BASE + {24'h0, off8}) : 32'hDEAD_BEEF;

    conv3x3_frame_sequencer #(
        .DATA_WIDHT(32), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(16), .DRAIN_TIMEOUT(TO)
    ) dut16 (
        .clk(clk), .rst(rst), .Start(start16), .Src_Base(src16), .Dst_Base(dst16),
        .Busy(busy16), .Done(done16), .Error(error16), .Out_Count(oc16),
        .Rd_En(rd_en16), .Rd_Addr(rd_addr16), .Rd_Data(rd_data16),
        .Conv_Clr(clr16), .Conv_Data(cdata16), .Conv_Valid(cvalid16),
        .Conv_Result(res_data), .Conv_Result_Valid(res_valid),
        .Wr_En(wr_en16), .Wr_Addr(wr_addr16), .Wr_Data(wr_data16)
    );

    conv3x3_frame_sequencer #(
        .DATA_WIDHT(32), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(8), .DRAIN_TIMEOUT(TO)
    ) dut8 (
        .clk(clk), .rst(rst), .Start(start8), .Src_Base(src8), .Dst_Base(dst8),
        .Busy(busy8), .Done(done8), .Error(error8), .Out_Count(oc8),
        .Rd_En(rd_en8), .Rd_Addr(rd_addr8), .Rd_Data(rd_data8),
        .Conv_Clr(clr8), .Conv_Data(cdata8), .Conv_Valid(cvalid8),
        .Conv_Result(res_data), .Conv_Result_Valid(res_valid),
        .Wr_En(wr_en8), .Wr_Addr(wr_addr8), .Wr_Data(wr_data8)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] rd_q16[$];
    logic [47:0] wr_q16[$];
    logic [7:0]  rd_q8[$];
    logic [39:0] wr_q8[$];

    int cyc = 0;
    int done_cnt16 = 0, clr_cnt16 = 0, cv_cnt16 = 0, wr_cnt16 = 0, wr_cnt8 = 0;
    int last_res_cyc = 0;

    int          result_limit = 9;
    int          pcount  = 0;
    int          emitted = 0;
    logic [31:0] pix_buf [0:W*H-1];
    logic [31:0] esum;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural engine: one result per complete 3x3 window, one cycle after its last pixel.
    always @(posedge clk) begin
        if (rst || clr16) begin
            pcount    = 0;
            emitted   = 0;
            eng_valid <= 1'b0;
        end else begin
            eng_valid <= 1'b0;
            if (cvalid16 && pcount < W*H) begin
                pix_buf[pcount] = cdata16;
                if ((pcount / W) >= 2 && (pcount % W) >= 2 && emitted < result_limit) begin
                    esum = '0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            esum = esum + pix_buf[pcount - i*W - j];
                    eng_valid <= 1'b1;
                    eng_data  <= esum;
                    emitted   = emitted + 1;
                end
                pcount = pcount + 1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a DUT issues a read or a write.
    always @(negedge clk) begin
        logic [47:0] e16;
        logic [39:0] e8;
        logic [15:0] a16;
        logic [7:0]  a8;
        if (rd_en16) begin
            if (rd_q16.size() == 0) checkOutput("rd16 unexpected read", {48'h0, rd_addr16}, 64'hFFFF_FFFF);
            else begin
                a16 = rd_q16.pop_front();
                checkOutput("rd16 addr", {48'h0, rd_addr16}, {48'h0, a16});
            end
        end
        if (wr_en16) begin
            wr_cnt16++;
            if (wr_q16.size() == 0) checkOutput("wr16 unexpected write", {16'h0, wr_addr16, wr_data16}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                e16 = wr_q16.pop_front();
                checkOutput("wr16 addr", {48'h0, wr_addr16}, {48'h0, e16[47:32]});
                checkOutput("wr16 data", {32'h0, wr_data16}, {32'h0, e16[31:0]});
            end
        end
        if (rd_en8) begin
            if (rd_q8.size() == 0) checkOutput("rd8 unexpected read", {56'h0, rd_addr8}, 64'hFFFF_FFFF);
            else begin
                a8 = rd_q8.pop_front();
                checkOutput("rd8 addr", {56'h0, rd_addr8}, {56'h0, a8});
            end
        end
        if (wr_en8) begin
            wr_cnt8++;
            if (wr_q8.size() == 0) checkOutput("wr8 unexpected write", {24'h0, wr_addr8, wr_data8}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                e8 = wr_q8.pop_front();
                checkOutput("wr8 addr", {56'h0, wr_addr8}, {56'h0, e8[39:32]});
                checkOutput("wr8 data", {32'h0, wr_data8}, {32'h0, e8[31:0]});
            end
        end
        if (done16)   done_cnt16++;
        if (clr16)    clr_cnt16++;
        if (cvalid16) cv_cnt16++;
        if (res_valid) last_res_cyc = cyc;
    end

    // Pushes the expected reads/writes of one frame, then pulses Start for one cycle.
    task automatic applyStimulus(input logic [15:0] src, input logic [15:0] dst, input int limit,
                                 input bit with8, input logic [7:0] s8, input logic [7:0] d8);
        logic [31:0] d;
        for (int k = 0; k < W*H; k++) begin
            rd_q16.push_back(src + 16'(k));
            if (with8) rd_q8.push_back(s8 + 8'(k));
        end
        for (int k = 0; k < limit; k++) begin
            d = 9 * PIX_BASE + 32'(9 * (5 * (k / 3) + (k % 3)) + 54);
            wr_q16.push_back({dst + 16'(k), d});
            if (with8) wr_q8.push_back({d8 + 8'(k), d});
        end
        mem_base16   = src;
        src16        = src;
        dst16        = dst;
        result_limit = limit;
        start16      = 1'b1;
        if (with8) begin
            mem_base8 = s8;
            src8      = s8;
            dst8      = d8;
            start8    = 1'b1;
        end
        tick();
        start16 = 1'b0;
        start8  = 1'b0;
    endtask

    // Returns during the DONE cycle, or after the budget with a failed check.
    task automatic waitFrame(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done16) break;
            tick();
        end
        checkOutput({name, " done seen"}, {63'h0, done16}, 64'h1);
    endtask

    task automatic checkIdleEnd(input string name);
        checkOutput({name, " rd queue drained"}, 64'(rd_q16.size()), 64'h0);
        checkOutput({name, " wr queue drained"}, 64'(wr_q16.size()), 64'h0);
        checkOutput({name, " busy low"}, {63'h0, busy16}, 64'h0);
    endtask

    initial begin
        int d0, c0, v0, w0, w8;
        int done_at;

        // Reset with random inputs; nothing must move.
        for (int i = 0; i < 3; i++) begin
            start16   = 1'($urandom);
            src16     = 16'($urandom);
            dst16     = 16'($urandom);
            inj_valid = 1'($urandom);
            inj_data  = $urandom;
            tick();
        end
        checkOutput("rst ctrl16", {57'h0, busy16, done16, error16, rd_en16, clr16, cvalid16, wr_en16}, 64'h0);
        checkOutput("rst out_count16", {32'h0, oc16}, 64'h0);
        checkOutput("rst addr16", {32'h0, rd_addr16, wr_addr16}, 64'h0);
        checkOutput("rst data16", {cdata16, wr_data16}, 64'h0);
        checkOutput("rst ctrl8", {57'h0, busy8, done8, error8, rd_en8, clr8, cvalid8, wr_en8}, 64'h0);
        rst       = 1'b0;
        start16   = 1'b0;
        inj_valid = 1'b0;
        tick();
        w0 = wr_cnt16;
        w8 = wr_cnt8;
        for (int i = 0; i < 3; i++) begin
            inj_valid = 1'b1;
            inj_data  = $urandom;
            tick();
        end
        inj_valid = 1'b0;
        tick();
        tick();
        checkOutput("idle results dropped16", 64'(wr_cnt16 - w0), 64'h0);
        checkOutput("idle results dropped8", 64'(wr_cnt8 - w8), 64'h0);

        // Nominal frame.
        d0 = done_cnt16; c0 = clr_cnt16; v0 = cv_cnt16;
        applyStimulus(16'h0100, 16'h0200, 9, 1'b0, 8'h0, 8'h0);
        checkOutput("nominal clr after start", {62'h0, clr16, busy16}, 64'h3);
        tick();
        checkOutput("nominal first read", {47'h0, rd_en16, rd_addr16}, {47'h0, 1'b1, 16'h0100});
        waitFrame("nominal", 100);
        checkOutput("nominal out_count", {32'h0, oc16}, 64'd9);
        checkOutput("nominal error", {63'h0, error16}, 64'h0);
        tick();
        tick();
        checkOutput("nominal done pulses", 64'(done_cnt16 - d0), 64'd1);
        checkOutput("nominal clr cycles", 64'(clr_cnt16 - c0), 64'd1);
        checkOutput("nominal conv_valid cycles", 64'(cv_cnt16 - v0), 64'd25);
        checkIdleEnd("nominal");

        // Start during FETCH and DONE ignored; Start in first IDLE cycle accepted.
        d0 = done_cnt16;
        applyStimulus(16'h0100, 16'h0200, 9, 1'b0, 8'h0, 8'h0);
        for (int i = 0; i < 5; i++) tick();
        src16 = 16'h0300; dst16 = 16'h0400; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        waitFrame("ignore", 100);
        src16 = 16'h0700; dst16 = 16'h0800; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        checkOutput("ignore idle after done", {63'h0, busy16}, 64'h0);
        checkOutput("ignore single done", 64'(done_cnt16 - d0), 64'd1);
        applyStimulus(16'h0500, 16'h0600, 9, 1'b0, 8'h0, 8'h0);
        checkOutput("relaunch clr", {63'h0, clr16}, 64'h1);
        waitFrame("relaunch", 100);
        tick();
        tick();
        checkOutput("relaunch done pulses", 64'(done_cnt16 - d0), 64'd2);
        checkIdleEnd("relaunch");

        // Drain timeout: only 7 results; Done follows 16 result-free cycles.
        applyStimulus(16'h0100, 16'h0200, 7, 1'b0, 8'h0, 8'h0);
        waitFrame("timeout", 200);
        done_at = cyc;
        checkOutput("timeout error", {63'h0, error16}, 64'h1);
        checkOutput("timeout out_count", {32'h0, oc16}, 64'd7);
        checkOutput("timeout done gap", 64'(done_at - last_res_cyc), 64'd17);
        tick();
        tick();
        checkOutput("timeout error held", {63'h0, error16}, 64'h1);
        checkIdleEnd("timeout");
        applyStimulus(16'h0100, 16'h0200, 9, 1'b0, 8'h0, 8'h0);
        checkOutput("error cleared on start", {63'h0, error16}, 64'h0);
        waitFrame("post-timeout", 100);
        checkOutput("post-timeout error", {63'h0, error16}, 64'h0);
        checkOutput("post-timeout out_count", {32'h0, oc16}, 64'd9);
        tick();
        tick();
        checkIdleEnd("post-timeout");

        // Reset at FETCH pixel 10.
        applyStimulus(16'h0100, 16'h0200, 9, 1'b0, 8'h0, 8'h0);
        for (int i = 0; i < 40; i++) begin
            if (rd_en16 && rd_addr16 == 16'h010A) break;
            tick();
        end
        checkOutput("midrst reached pixel 10", {48'h0, rd_addr16}, 64'h010A);
        rst = 1'b1;
        tick();
        checkOutput("midrst ctrl", {57'h0, busy16, done16, error16, rd_en16, clr16, cvalid16, wr_en16}, 64'h0);
        checkOutput("midrst out_count", {32'h0, oc16}, 64'h0);
        checkOutput("midrst addr", {32'h0, rd_addr16, wr_addr16}, 64'h0);
        checkOutput("midrst data", {cdata16, wr_data16}, 64'h0);
        rst = 1'b0;
        rd_q16.delete();
        wr_q16.delete();
        tick();
        w0 = wr_cnt16;
        applyStimulus(16'h0100, 16'h0200, 9, 1'b0, 8'h0, 8'h0);
        tick();
        checkOutput("midrst restart read", {47'h0, rd_en16, rd_addr16}, {47'h0, 1'b1, 16'h0100});
        waitFrame("midrst", 100);
        tick();
        tick();
        checkOutput("midrst writes", 64'(wr_cnt16 - w0), 64'd9);
        checkIdleEnd("midrst");

        // Address wrap on the 8-bit instance.
        w8 = wr_cnt8;
        applyStimulus(16'h00F0, 16'h00FC, 9, 1'b1, 8'hF0, 8'hFC);
        waitFrame("wrap", 100);
        checkOutput("wrap done8", {63'h0, done8}, 64'h1);
        checkOutput("wrap out_count8", {32'h0, oc8}, 64'd9);
        checkOutput("wrap error8", {63'h0, error8}, 64'h0);
        tick();
        tick();
        checkOutput("wrap writes8", 64'(wr_cnt8 - w8), 64'd9);
        checkOutput("wrap rd8 drained", 64'(rd_q8.size()), 64'h0);
        checkOutput("wrap wr8 drained", 64'(wr_q8.size()), 64'h0);
        checkIdleEnd("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
